// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM frame controller.
// Holds the FSM state encoding, frame geometry and the channel slice helper.
// Pure declarations; no logic, no latency, no flow control.
package tdm_pkg;

  localparam int NCH     = 8;
  localparam int WORD    = 32;
  localparam int FRAME_W = NCH * WORD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    RUN     = 2'd2,
    RESTART = 2'd3
  } state_e;

  typedef logic [WORD-1:0]           word_t;
  typedef logic [$clog2(NCH)-1:0]    ch_t;
  // Element [NCH-1] is the most significant slice, which carries CH1.
  typedef logic [NCH-1:0][WORD-1:0]  frame_t;

  // Channel k (0 = CH1) lives in element NCH-1-k of the packed frame.
  function automatic word_t ch_slice(input frame_t f, input ch_t k);
    ch_t idx;
    idx = ch_t'(NCH - 1) - k;
    return f[idx];
  endfunction

endpackage

// File: rtl/tdm_frame_fifo.sv
// Two-entry frame buffer between the deserializer and the word serializer.
// Latency: a pushed frame is visible at the head the cycle after the push.
// Backpressure: a push into a full FIFO is ignored unless a pop happens the same cycle.
//
// Ports: i_clk/i_rstn (sync active-low reset), i_flush (sync clear),
//        i_push_vld/i_push_dat (write side), i_pop (remove head),
//        o_head_dat (current head frame), o_full/o_empty (occupancy flags).
module tdm_frame_fifo
  import tdm_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rstn,
  input  logic   i_flush,
  input  logic   i_push_vld,
  input  frame_t i_push_dat,
  input  logic   i_pop,
  output frame_t o_head_dat,
  output logic   o_full,
  output logic   o_empty
);

  frame_t     r_mem [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;
  logic       w_wr;
  logic       w_rd;

  assign o_full     = (r_cnt == 2'd2);
  assign o_empty    = (r_cnt == 2'd0);
  assign w_rd       = i_pop && !o_empty;
  // When full, the write slot equals the head slot; the head is read
  // combinationally this cycle, so overwriting it on the same edge is safe.
  assign w_wr       = i_push_vld && (!o_full || w_rd);
  assign o_head_dat = r_mem[r_rp];

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_wr) r_wp <= ~r_wp;
      if (w_rd) r_rp <= ~r_rp;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_push_dat;
  end

endmodule

// File: rtl/tdm_frame_ctrl.sv
// Deserializer control FSM, sync watchdog and frame-to-word serializer.
// Latency: frame strobe in cycle N gives CH1 on the output in cycle N+1 (FIFO empty).
// Backpressure: out_ready stalls the word stream; frames arriving to a full FIFO are dropped and counted.
//
// Ports: clk, rstn (sync active-low), run (capture enable level),
//        des_enable/des_valid/des_pdata (deserializer side),
//        out_valid/out_ready/out_ch/out_data/out_last (word stream),
//        overrun/timeout (status pulses), overrun_cnt (saturating drops), state (FSM).
// Build option: define TDM_WATCHDOG_EN to build the watchdog and the RESTART sequence.
module tdm_frame_ctrl
  import tdm_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int RST_CYC = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  output logic               des_enable,
  input  logic               des_valid,
  input  logic [FRAME_W-1:0] des_pdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_ch,
  output logic [WORD-1:0]    out_data,
  output logic               out_last,
  output logic               overrun,
  output logic               timeout,
  output logic [15:0]        overrun_cnt,
  output logic [1:0]         state
);

  state_e      r_state;
  logic        r_des_enable;
  logic        r_overrun;
  logic [15:0] r_overrun_cnt;
  ch_t         r_k;

  frame_t      w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_acc;
  logic        w_pop;
  logic        w_drop;

  // Capture only while enabled and the deserializer is live; run=0 overrides all.
  assign w_push = run && des_valid && ((r_state == SYNC) || (r_state == RUN));
  assign w_acc  = !w_empty && out_ready;
  assign w_pop  = w_acc && (r_k == ch_t'(NCH - 1));
  assign w_drop = w_push && w_full && !w_pop;

  tdm_frame_fifo u_fifo (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_flush    (!run),
    .i_push_vld (w_push),
    .i_push_dat (frame_t'(des_pdata)),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Word index within the head frame; cleared together with the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      r_k <= '0;
    end else if (w_acc) begin
      r_k <= r_k + ch_t'(1);
    end
  end

  assign out_valid = !w_empty;
  assign out_ch    = r_k;
  assign out_data  = w_empty ? '0 : ch_slice(w_head, r_k);
  assign out_last  = !w_empty && (r_k == ch_t'(NCH - 1));

`ifdef TDM_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  logic [WD_W-1:0] r_wd;
  logic [RC_W-1:0] r_rc;
  logic            r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_des_enable  <= 1'b0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
`ifdef TDM_WATCHDOG_EN
      r_wd          <= '0;
      r_rc          <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_overrun <= w_drop;
      if (w_drop && (r_overrun_cnt != 16'hFFFF)) begin
        r_overrun_cnt <= r_overrun_cnt + 16'd1;
      end
`ifdef TDM_WATCHDOG_EN
      r_timeout <= 1'b0;
`endif
      if (!run) begin
        r_state      <= IDLE;
        r_des_enable <= 1'b0;
`ifdef TDM_WATCHDOG_EN
        r_wd         <= '0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= SYNC;
            r_des_enable <= 1'b1;
`ifdef TDM_WATCHDOG_EN
            r_wd         <= '0;
`endif
          end
          SYNC, RUN: begin
            if (des_valid) begin
              r_state <= RUN;
`ifdef TDM_WATCHDOG_EN
              r_wd    <= '0;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
              // Timeout pulse and RESTART entry share the same edge.
              r_timeout    <= 1'b1;
              r_state      <= RESTART;
              r_des_enable <= 1'b0;
              r_rc         <= '0;
            end else begin
              r_wd <= r_wd + WD_W'(1);
`endif
            end
          end
`ifdef TDM_WATCHDOG_EN
          RESTART: begin
            if (r_rc == RC_W'(RST_CYC - 1)) begin
              r_state      <= SYNC;
              r_des_enable <= 1'b1;
              r_wd         <= '0;
            end else begin
              r_rc <= r_rc + RC_W'(1);
            end
          end
`endif
          default: begin
            r_state      <= IDLE;
            r_des_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  assign des_enable  = r_des_enable;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_tdm_frame_ctrl.sv
// Directed bench for tdm_frame_ctrl: reset, streaming, overrun, same-cycle
// pop/push, watchdog restart, run abort, counter saturation, reset mid-frame.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_tdm_frame_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         run;
  logic         des_valid;
  logic [255:0] des_pdata;
  logic         out_ready;
  logic         des_enable;
  logic         out_valid;
  logic [2:0]   out_ch;
  logic [31:0]  out_data;
  logic         out_last;
  logic         overrun;
  logic         timeout;
  logic [15:0]  overrun_cnt;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_ovr = 16'd0;

  tdm_frame_ctrl #(.TIMEOUT(16), .RST_CYC(4)) dut (
    .clk(clk), .rstn(rstn), .run(run), .des_enable(des_enable),
    .des_valid(des_valid), .des_pdata(des_pdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_last(out_last), .overrun(overrun),
    .timeout(timeout), .overrun_cnt(overrun_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel i word of the frame tagged by seed; seed 0 yields 0x11111111..0x88888888.
  function automatic logic [31:0] exp_word(input logic [31:0] seed, input int i);
    return seed ^ (32'h11111111 * (i + 1));
  endfunction

  function automatic logic [255:0] mk_frame(input logic [31:0] seed);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[255 - 32*i -: 32] = exp_word(seed, i);
    return f;
  endfunction

  task automatic start_run();
    run = 1'b0; step();
    run = 1'b1; step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; run = 1'b0; des_valid = 1'b0; des_pdata = '0; out_ready = 1'b0;
    step(); step();
    n_tests++; if (des_enable !== 1'b0) begin n_fail++; $display("FAIL reset_des_enable: got %b want 0", des_enable); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_tests++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_overrun_cnt: got %h want 0", overrun_cnt); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    rstn = 1'b1; step();
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_hold_state: got %0d want 0", state); end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    run = 1'b1; step();
    n_tests++; if (des_enable !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL sync_entry: got en=%b st=%0d want en=1 st=1", des_enable, state); end
    des_valid = 1'b1; des_pdata = mk_frame(32'h0); step(); des_valid = 1'b0;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL run_entry: got st=%0d want 2", state); end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 3'(k) || out_data !== exp_word(32'h0, k) || out_last !== (k == 7)) begin
        n_fail++; $display("FAIL single_word%0d: got v=%b ch=%0d d=%h l=%b want v=1 ch=%0d d=%h l=%b",
                           k, out_valid, out_ch, out_data, out_last, k, exp_word(32'h0, k), (k == 7));
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0 || state !== 2'd2) begin n_fail++; $display("FAIL single_end: got v=%b st=%0d want v=0 st=2", out_valid, state); end
  endtask

  task automatic test_overrun();
    logic [31:0] seeds [2];
    seeds[0] = 32'hA0000000; seeds[1] = 32'h0B000000;
    start_run();
    out_ready = 1'b0;
    des_valid = 1'b1;
    des_pdata = mk_frame(seeds[0]); step();
    des_pdata = mk_frame(seeds[1]); step();
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_no_early_pulse: got %b want 0", overrun); end
    des_pdata = mk_frame(32'h00C00000); step(); des_valid = 1'b0;
    exp_ovr = exp_ovr + 16'd1;
    n_tests++; if (overrun !== 1'b1 || overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL ovr_pulse: got p=%b cnt=%h want p=1 cnt=%h", overrun, overrun_cnt, exp_ovr); end
    n_tests++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== exp_word(seeds[0], 0)) begin n_fail++; $display("FAIL ovr_stall_hold: got v=%b ch=%0d d=%h", out_valid, out_ch, out_data); end
    step();
    n_tests++; if (overrun !== 1'b0 || overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL ovr_single_pulse: got p=%b cnt=%h want p=0 cnt=%h", overrun, overrun_cnt, exp_ovr); end
    out_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 3'(w % 8) || out_data !== exp_word(seeds[w/8], w % 8) || out_last !== ((w % 8) == 7)) begin
        n_fail++; $display("FAIL ovr_drain%0d: got v=%b ch=%0d d=%h l=%b want ch=%0d d=%h",
                           w, out_valid, out_ch, out_data, out_last, w % 8, exp_word(seeds[w/8], w % 8));
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_third_dropped: got v=%b want 0", out_valid); end
  endtask

  task automatic test_full_accept();
    logic [31:0] seeds [3];
    seeds[0] = 32'h000D0000; seeds[1] = 32'h0000E000; seeds[2] = 32'h00000F00;
    start_run();
    out_ready = 1'b0;
    des_valid = 1'b1;
    des_pdata = mk_frame(seeds[0]); step();
    des_pdata = mk_frame(seeds[1]); step();
    des_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (out_data !== exp_word(seeds[0], k) || out_ch !== 3'(k)) begin n_fail++; $display("FAIL fa_head%0d: got ch=%0d d=%h want d=%h", k, out_ch, out_data, exp_word(seeds[0], k)); end
      step();
    end
    n_tests++; if (out_last !== 1'b1 || out_data !== exp_word(seeds[0], 7)) begin n_fail++; $display("FAIL fa_ch8: got l=%b d=%h", out_last, out_data); end
    des_valid = 1'b1; des_pdata = mk_frame(seeds[2]); step(); des_valid = 1'b0;
    n_tests++; if (overrun !== 1'b0 || overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL fa_no_overrun: got p=%b cnt=%h want p=0 cnt=%h", overrun, overrun_cnt, exp_ovr); end
    for (int w = 0; w < 16; w++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 3'(w % 8) || out_data !== exp_word(seeds[1 + w/8], w % 8)) begin
        n_fail++; $display("FAIL fa_drain%0d: got v=%b ch=%0d d=%h want d=%h", w, out_valid, out_ch, out_data, exp_word(seeds[1 + w/8], w % 8));
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fa_empty: got v=%b want 0", out_valid); end
  endtask

  task automatic test_watchdog();
    int early;
    early = 0;
    start_run();
`ifdef TDM_WATCHDOG_EN
    for (int c = 1; c < 16; c++) begin
      step();
      if (timeout !== 1'b0 || state !== 2'd1) early++;
    end
    n_tests++; if (early != 0) begin n_fail++; $display("FAIL wd_early: got %0d early cycles want 0", early); end
    step();
    n_tests++; if (timeout !== 1'b1 || state !== 2'd3 || des_enable !== 1'b0) begin n_fail++; $display("FAIL wd_fire: got t=%b st=%0d en=%b want t=1 st=3 en=0", timeout, state, des_enable); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (timeout !== 1'b0 || des_enable !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL wd_restart%0d: got t=%b en=%b st=%0d", c, timeout, des_enable, state); end
    end
    step();
    n_tests++; if (des_enable !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL wd_resync: got en=%b st=%0d want en=1 st=1", des_enable, state); end
`else
    for (int c = 0; c < 40; c++) begin
      step();
      if (timeout !== 1'b0) early++;
    end
    n_tests++; if (early != 0) begin n_fail++; $display("FAIL wd_off_timeout: got %0d pulses want 0", early); end
    n_tests++; if (state !== 2'd1 || des_enable !== 1'b1) begin n_fail++; $display("FAIL wd_off_sync: got st=%0d en=%b want st=1 en=1", state, des_enable); end
`endif
  endtask

  task automatic test_run_abort();
    start_run();
    out_ready = 1'b1;
    des_valid = 1'b1; des_pdata = mk_frame(32'h5A5A0000); step(); des_valid = 1'b0;
    step(); step(); step();
    n_tests++; if (out_ch !== 3'd3 || out_data !== exp_word(32'h5A5A0000, 3)) begin n_fail++; $display("FAIL abort_pre: got ch=%0d d=%h want ch=3", out_ch, out_data); end
    run = 1'b0; step();
    n_tests++; if (out_valid !== 1'b0 || des_enable !== 1'b0 || state !== 2'd0 || out_ch !== 3'd0) begin n_fail++; $display("FAIL abort_idle: got v=%b en=%b st=%0d ch=%0d", out_valid, des_enable, state, out_ch); end
    n_tests++; if (overrun_cnt !== exp_ovr) begin n_fail++; $display("FAIL abort_cnt_kept: got %h want %h", overrun_cnt, exp_ovr); end
    run = 1'b1; step(); step();
    n_tests++; if (out_valid !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL abort_flushed: got v=%b st=%0d want v=0 st=1", out_valid, state); end
  endtask

  task automatic test_saturation();
    start_run();
    out_ready = 1'b0;
    des_valid = 1'b1; des_pdata = mk_frame(32'h77770000);
    step(); step();
    for (int i = 0; i < 32'h10000; i++) begin
      step();
      exp_ovr = (exp_ovr == 16'hFFFF) ? exp_ovr : exp_ovr + 16'd1;
      if (exp_ovr == 16'hFFFE) begin
        n_tests++; if (overrun_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", overrun_cnt); end
      end
    end
    n_tests++; if (overrun_cnt !== 16'hFFFF || overrun !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got cnt=%h p=%b want ffff 1", overrun_cnt, overrun); end
    des_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b1; step(); step();
    n_tests++; if (out_ch !== 3'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rmf_pre: got ch=%0d v=%b want ch=2 v=1", out_ch, out_valid); end
    rstn = 1'b0; step();
    n_tests++; if (out_valid !== 1'b0 || out_data !== 32'd0 || overrun_cnt !== 16'd0 || state !== 2'd0 || des_enable !== 1'b0) begin
      n_fail++; $display("FAIL rmf_clear: got v=%b d=%h cnt=%h st=%0d en=%b", out_valid, out_data, overrun_cnt, state, des_enable);
    end
    rstn = 1'b1; step();
    n_tests++; if (out_valid !== 1'b0 || state !== 2'd1) begin n_fail++; $display("FAIL rmf_after: got v=%b st=%0d want v=0 st=1", out_valid, state); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_full_accept();
    test_watchdog();
    test_run_abort();
    test_saturation();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_frame_ctrl.md
# tdm_frame_ctrl

Controller and frame scheduler for the 8-channel TDM deserializer. Drives the deserializer enable, recovers from lost sync with a restart sequence, and buffers its 256-bit frames in a 2-entry frame FIFO. Frames are streamed downstream as eight 32-bit channel words over a valid/ready interface. Sits between the ADC deserializer and the mixer/packetizer.

## Interface

- NCH, 8: channels per frame (fixed; 8 × WORD = 256)
- WORD, 32: bits per channel sample
- TIMEOUT, 4096: watchdog limit, clk cycles without a frame
- RST_CYC, 4: cycles des_enable is held low during restart
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- run  in  1  level; 1 = capture enabled
- des_enable  out  1  enable to deserializer
- des_valid  in  1  single-cycle frame strobe from deserializer
- des_pdata  in  256  frame; [255:224] = CH1 … [31:0] = CH8
- out_valid  out  1  channel word available
- out_ready  in  1  downstream accepts word
- out_ch  out  3  channel index, 0 = CH1
- out_data  out  32  channel sample
- out_last  out  1  high with CH8 word
- overrun  out  1  one-cycle pulse, frame dropped
- timeout  out  1  one-cycle pulse, watchdog fired
- overrun_cnt  out  16  saturating dropped-frame count
- state  out  2  FSM state for status readback

## Operation

- FSM states: IDLE=0, SYNC=1, RUN=2, RESTART=3.
- IDLE → SYNC when run=1. des_enable=1 in SYNC and RUN; 0 in IDLE and RESTART.
- SYNC → RUN on the first des_valid. That frame is pushed.
- Any state → IDLE when run=0. This has priority over all other transitions. The FIFO, the output word index and the watchdog are flushed. overrun_cnt is kept.
- RESTART: lasts RST_CYC cycles, then → SYNC. The FIFO is not flushed; frames already buffered still drain.
- Push: on des_valid in SYNC/RUN.
  - If FIFO has a free entry, push.
  - If full and the head's CH8 word is accepted the same cycle, push (no overrun).
  - Otherwise drop the frame, pulse overrun, and increment overrun_cnt, saturating at 0xFFFF.
  - des_valid in IDLE/RESTART is ignored.
- Serializer: while the FIFO is non-empty, out_valid=1. out_data = head slice [255−32·k −: 32] for k = out_ch. A word is transferred when out_valid && out_ready; then k increments. Accepting k=7 pops the head and resets k to 0.
- out_data, out_ch and out_last stay stable while out_valid && !out_ready.

## Timing

- Reset values: des_enable=0, out_valid=0, out_ch=0, out_data=0, out_last=0, overrun=0, timeout=0, overrun_cnt=0, state=IDLE. FIFO is empty.
- des_enable rises 1 cycle after run rises (IDLE→SYNC registered). It falls 1 cycle after run falls.
- Frame latency: des_valid in cycle N gives out_valid=1 with CH1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word per cycle at out_ready=1. A frame drains in 8 cycles. The next frame follows with no bubble.
- Watchdog counts clk cycles in SYNC/RUN since entry or since the last des_valid. When the count reaches TIMEOUT−1 without a frame: timeout pulses, and the FSM enters RESTART on the next cycle. des_valid in the same cycle wins and clears the count.
- Reset mid-frame discards everything, with no partial output.

## Configuration

- TDM_WATCHDOG_EN defined: the watchdog and the RESTART state exist as described.
- TDM_WATCHDOG_EN undefined: no counter is built, timeout is tied to 0, and RESTART is unreachable. SYNC waits indefinitely for a frame.

## Structure

- Shared package tdm_pkg holds:
  - the state enum (IDLE/SYNC/RUN/RESTART)
  - NCH and WORD constants
  - the frame/channel-slice typedefs
- Sub-module tdm_frame_fifo: 2-entry × 256-bit synchronous FIFO with push, pop, full and empty flags. Simultaneous push and pop when full is legal.
- The FSM, watchdog and serializer live in tdm_frame_ctrl.

## Test plan

- Reset, then run=1, one frame 0x11111111…0x88888888 (CH1→CH8), out_ready=1 → 8 words out_ch 0..7, data 0x11111111..0x88888888, out_last on ch 7, state=RUN.
- out_ready=0 with three frames arriving → two buffered, third dropped: overrun pulses once, overrun_cnt=1. Releasing ready then gives 16 words from frames 1 and 2.
- Full FIFO with the CH8 accept in the same cycle as des_valid → no overrun; the new frame is output after the current head drains.
- TDM_WATCHDOG_EN, TIMEOUT=16, no des_valid after SYNC → timeout pulses at cycle 16, des_enable low for 4 cycles, then high again in SYNC.
- run deasserted mid-frame at out_ch=3 → out_valid=0 next cycle, FIFO empty, des_enable=0, state=IDLE, overrun_cnt retained.
- 0x10000 forced overruns → overrun_cnt saturates at 0xFFFF.
